// File: rtl/gpr_mp_sb.sv
// Multi-port general-purpose register file with a per-register busy scoreboard.
// It has two prioritised write ports, optional write-through bypass and a popcount of busy registers.
module gpr_mp_sb #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int NRP      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NRP*AW-1:0] raddr,
   output logic [NRP*DW-1:0] rdata,
   output logic [NRP-1:0]    rbusy,
   input  logic              we0,
   input  logic [AW-1:0]     waddr0,
   input  logic [DW-1:0]     wdata0,
   input  logic              we1,
   input  logic [AW-1:0]     waddr1,
   input  logic [DW-1:0]     wdata1,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_addr,
   input  logic              flush,
   output logic [AW:0]       busy_cnt
);

   localparam int DEPTH = 1 << AW;
   localparam bit ZR    = (ZERO_REG != 0);
   localparam bit BP    = (BYPASS != 0);

   logic [DW-1:0]    regs [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;
   logic             wr0_ok;
   logic             wr1_ok;

   // Port 0 yields to port 1 on an address collision so only one store lands per register.
   assign wr1_ok = we1 && !(ZR && (waddr1 == '0));
   assign wr0_ok = we0 && !(ZR && (waddr0 == '0)) && !(we1 && (waddr1 == waddr0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (wr0_ok) begin
            regs[waddr0] <= wdata0;
         end
         if (wr1_ok) begin
            regs[waddr1] <= wdata1;
         end
      end
   end

   // An issue outranks a same-cycle writeback because the newly issued producer has not yet written.
   always_comb begin
      busy_nxt = busy;
      for (int r = 0; r < DEPTH; r++) begin
         if (flush) begin
            busy_nxt[r] = 1'b0;
         end else if (iss_valid && (iss_addr == AW'(r)) && !(ZR && (r == 0))) begin
            busy_nxt[r] = 1'b1;
         end else if ((we0 && (waddr0 == AW'(r))) || (we1 && (waddr1 == AW'(r)))) begin
            busy_nxt[r] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   always_comb begin
      busy_cnt = '0;
      for (int r = 0; r < DEPTH; r++) begin
         busy_cnt = busy_cnt + (AW+1)'(busy[r]);
      end
   end

   for (genvar k = 0; k < NRP; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      logic          rb;

      assign ra = raddr[k*AW +: AW];

      // Forwarded data is current, so the busy flag is masked alongside it.
      always_comb begin
         rd = regs[ra];
         rb = busy[ra];
         if (BP && we0 && (waddr0 == ra)) begin
            rd = wdata0;
            rb = 1'b0;
         end
         if (BP && we1 && (waddr1 == ra)) begin
            rd = wdata1;
            rb = 1'b0;
         end
         if (ZR && (ra == '0)) begin
            rd = '0;
            rb = 1'b0;
         end
      end

      assign rdata[k*DW +: DW] = rd;
      assign rbusy[k]          = rb;
   end

endmodule
